stream_arbiter_wrr: RTL and testbench
=====================================

// Module: stream_arbiter_wrr
// PURPOSE
//  Weighted round-robin N:1 stream arbiter with packet locking, successor to the plain rr/prio stream arbiter.
//  Input k may complete up to weight_i[k] consecutive packets before priority moves on.
//  Once a packet starts, the grant holds until its last beat, so multi-beat bursts are never interleaved.
//  Sits in front of shared interconnect ports, DMA back-ends and memory request muxes.
// PARAMETERS
//  DATA_WIDTH    32   payload width per input.
//  N_INP         4    number of inputs; must be >= 1.
//  WEIGHT_WIDTH  4    width of each per-input weight.
//  IDX_WIDTH     (N_INP>1 ? $clog2(N_INP) : 1)   derived; do not override.
// PORTS
//  clk_i        in   1                      clock, rising edge
//  rst_i        in   1                      reset, synchronous, active-high
//  clr_i        in   1                      synchronous clear of arbitration state
//  weight_i     in   N_INP*WEIGHT_WIDTH     weight of input k at bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//  inp_data_i   in   N_INP*DATA_WIDTH       payload of input k, same packing as weight_i
//  inp_last_i   in   N_INP                  last beat of packet, per input
//  inp_valid_i  in   N_INP                  valid, per input
//  inp_ready_o  out  N_INP                  ready, per input
//  oup_data_o   out  DATA_WIDTH             granted payload
//  oup_last_o   out  1                      granted last flag
//  oup_idx_o    out  IDX_WIDTH              index of granted input
//  oup_valid_o  out  1                      output valid
//  oup_ready_i  in   1                      output ready
// BEHAVIOUR
//  - State: ptr (IDX_WIDTH, priority head), cnt (WEIGHT_WIDTH, packets done by ptr), lock (1), owner (IDX_WIDTH).
//  - Reset: rst_i=1 at a clock edge sets ptr=0, cnt=0, lock=0, owner=0.
//    While rst_i=1: oup_valid_o=0, inp_ready_o=0, oup_idx_o=0.
//  - eff_w(k) = (weight_i[k]==0) ? 1 : weight_i[k]. A weight of 0 never starves an input.
//  - Grant selection (combinational, zero latency):
//    - lock=1: sel=owner.
//    - lock=0: sel = first k with inp_valid_i[k]=1, searching ptr, ptr+1, ... in cyclic order, wrapping at N_INP-1 -> 0.
//      If no input is valid, sel=ptr.
//  - Outputs: oup_valid_o=inp_valid_i[sel]; oup_data_o, oup_last_o and oup_idx_o come from sel.
//    inp_ready_o[sel]=oup_ready_i; every other inp_ready_o bit is 0.
//  - Handshake is oup_valid_o & oup_ready_i. State changes only on a handshake or on clr_i.
//    Therefore sel, data and idx stay stable under backpressure as long as the inputs obey AXI-stream rules.
//  - Handshake with oup_last_o=0: lock<=1, owner<=sel.
//  - Handshake with oup_last_o=1 (packet done by k=sel): lock<=0.
//    n = (k==ptr) ? cnt+1 : 1.
//    If n >= eff_w(k): ptr<=(k+1) mod N_INP, cnt<=0. Otherwise: ptr<=k, cnt<=n.
//  - Weights are sampled combinationally at packet completion. A change takes effect at the next completion.
//  - clr_i=1: same state update as reset, and it takes priority over a coincident handshake.
//    That beat still transfers on the output; only the state is cleared. Outputs are not forced low.
//  - Reset or clear mid-packet drops the lock. The remaining beats are arbitrated as fresh traffic.
//  - N_INP=1: pure pass-through with oup_idx_o=0 and the counters inert.
//  - Throughput is one beat per cycle. There is no bubble between packets or between inputs.
// CONFIGURATION
//  Macro STREAM_ARBITER_WRR_OUT_REG_EN.
//  - Defined: a full-throughput output register stage (pipeline plus spill) holds data, last, idx and valid.
//    Latency 1 cycle; oup_valid_o reset 0. inp_ready_o[sel] = stage can accept.
//    Arbitration state advances on the input-side handshake.
//  - Undefined: fully combinational path, latency 0, exactly as described above.
// TESTING
//  1. N_INP=3, weights {1,2,3}, all valid, last=1, oup_ready=1 -> oup_idx_o sequence 0,1,1,2,2,2,0,1,1,...
//  2. In0 sends a 3-beat packet while in1 is valid throughout, with oup_ready toggling 1,0,1,0,1
//     -> three in0 beats, idx=0 throughout, then idx=1.
//  3. All valid, oup_ready=0 for 5 cycles -> oup_data_o and oup_idx_o constant, all inp_ready_o=0, state unchanged.
//  4. weight_i all 0, N_INP=4, all valid, single beats -> idx 0,1,2,3,0.
//     Only in2 valid -> idx=2 on every cycle with no stalls.
//  5. clr_i pulsed after beat 1 of a 4-beat in3 packet, with ptr=3 and in0 valid
//     -> next grant is idx 0 (lock dropped, ptr=0).
//  6. STREAM_ARBITER_WRR_OUT_REG_EN defined, test 1 stimulus -> same idx sequence delayed by 1 cycle,
//     one beat per cycle, oup_valid_o=0 in the cycle after reset.

Source files
------------

// File: rtl/stream_arbiter_wrr_if.sv
// Stream bundle between N input streams and the single arbitrated output stream.
// master = traffic side (sources and sink), slave = arbiter.
interface stream_arbiter_wrr_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int N_INP       = 4,
   localparam int IDX_WIDTH  = (N_INP > 1) ? $clog2(N_INP) : 1
);
   logic [N_INP*DATA_WIDTH-1:0] inp_data;
   logic [N_INP-1:0]            inp_last;
   logic [N_INP-1:0]            inp_valid;
   logic [N_INP-1:0]            inp_ready;
   logic [DATA_WIDTH-1:0]       oup_data;
   logic                        oup_last;
   logic [IDX_WIDTH-1:0]        oup_idx;
   logic                        oup_valid;
   logic                        oup_ready;

   modport master (
      output inp_data, inp_last, inp_valid, oup_ready,
      input  inp_ready, oup_data, oup_last, oup_idx, oup_valid
   );

   modport slave (
      input  inp_data, inp_last, inp_valid, oup_ready,
      output inp_ready, oup_data, oup_last, oup_idx, oup_valid
   );
endinterface

// File: rtl/stream_arbiter_wrr.sv
// Weighted round-robin N:1 stream arbiter with packet locking; latency 0, or 1 with STREAM_ARBITER_WRR_OUT_REG_EN.
// Backpressure: only the granted input sees ready; the grant is frozen until its beat hands off.
module stream_arbiter_wrr #(
   parameter int DATA_WIDTH   = 32,
   parameter int N_INP        = 4,
   parameter int WEIGHT_WIDTH = 4,
   localparam int IDX_WIDTH   = (N_INP > 1) ? $clog2(N_INP) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clr_i,
   input  logic [N_INP*WEIGHT_WIDTH-1:0] weight_i,
   stream_arbiter_wrr_if.slave           bus
);
   typedef enum logic {ST_FREE, ST_LOCK} state_t;

   state_t                state_q, state_d;
   logic [IDX_WIDTH-1:0]  ptr_q, ptr_d, owner_q, owner_d, sel;
   logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d, w_raw;
   logic [WEIGHT_WIDTH:0] eff_w, n;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_vld, sel_last, accept, in_hs;

   always_comb begin : p_select
      int  j;
      logic found;
      j     = 0;
      found = 1'b0;
      sel   = ptr_q;
      if (state_q == ST_LOCK) begin
         sel = owner_q;
      end else begin
         for (int i = 0; i < N_INP; i++) begin
            j = (int'(ptr_q) + i) % N_INP;
            if (!found && bus.inp_valid[j]) begin
               sel   = IDX_WIDTH'(j);
               found = 1'b1;
            end
         end
      end
   end

   assign sel_vld  = bus.inp_valid[sel];
   assign sel_last = bus.inp_last[sel];
   assign sel_data = bus.inp_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign w_raw    = weight_i[int'(sel)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
   // A zero weight still grants one packet per turn.
   assign eff_w    = (w_raw == '0) ? (WEIGHT_WIDTH+1)'(1) : {1'b0, w_raw};
   assign n        = (sel == ptr_q) ? ({1'b0, cnt_q} + (WEIGHT_WIDTH+1)'(1))
                                    : (WEIGHT_WIDTH+1)'(1);
   assign in_hs    = sel_vld & accept;

   always_comb begin : p_next
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      if (clr_i) begin
         state_d = ST_FREE;
         ptr_d   = '0;
         cnt_d   = '0;
         owner_d = '0;
      end else if (in_hs) begin
         if (!sel_last) begin
            state_d = ST_LOCK;
            owner_d = sel;
         end else begin
            state_d = ST_FREE;
            if (N_INP == 1) begin
               ptr_d = '0;
               cnt_d = '0;
            end else if (n >= eff_w) begin
               ptr_d = IDX_WIDTH'((int'(sel) + 1) % N_INP);
               cnt_d = '0;
            end else begin
               ptr_d = sel;
               cnt_d = n[WEIGHT_WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_FREE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      bus.inp_ready      = '0;
      bus.inp_ready[sel] = accept;
   end

`ifdef STREAM_ARBITER_WRR_OUT_REG_EN
   logic                  main_vld, main_last, spill_vld, spill_last;
   logic [DATA_WIDTH-1:0] main_data, spill_data;
   logic [IDX_WIDTH-1:0]  main_idx, spill_idx;

   // The spill slot catches the beat accepted in the cycle the sink first stalls.
   assign accept = ~spill_vld & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_vld   <= 1'b0;
         main_last  <= 1'b0;
         main_data  <= '0;
         main_idx   <= '0;
         spill_vld  <= 1'b0;
         spill_last <= 1'b0;
         spill_data <= '0;
         spill_idx  <= '0;
      end else if (!main_vld || bus.oup_ready) begin
         if (spill_vld) begin
            main_vld  <= 1'b1;
            main_last <= spill_last;
            main_data <= spill_data;
            main_idx  <= spill_idx;
            spill_vld <= 1'b0;
         end else begin
            main_vld  <= in_hs;
            main_last <= sel_last;
            main_data <= sel_data;
            main_idx  <= sel;
         end
      end else if (in_hs) begin
         spill_vld  <= 1'b1;
         spill_last <= sel_last;
         spill_data <= sel_data;
         spill_idx  <= sel;
      end
   end

   assign bus.oup_valid = main_vld & ~rst_i;
   assign bus.oup_data  = main_data;
   assign bus.oup_last  = main_last;
   assign bus.oup_idx   = rst_i ? '0 : main_idx;
`else
   assign accept        = bus.oup_ready & ~rst_i;
   assign bus.oup_valid = sel_vld & ~rst_i;
   assign bus.oup_data  = sel_data;
   assign bus.oup_last  = sel_last;
   assign bus.oup_idx   = rst_i ? '0 : sel;
`endif
endmodule

// File: tb/tb_stream_arbiter_wrr.sv
// Bench for stream_arbiter_wrr: a 3-input instance (weights 1,2,3) and a 4-input instance (weights 0).
// Table-driven per-cycle vectors; multi-cycle corners are written as consecutive table rows.
module tb_stream_arbiter_wrr;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr3 = 1'b0;
   logic clr4 = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   stream_arbiter_wrr_if #(.DATA_WIDTH(32), .N_INP(3)) b3 ();
   stream_arbiter_wrr_if #(.DATA_WIDTH(32), .N_INP(4)) b4 ();

   logic [11:0] w3 = {4'd3, 4'd2, 4'd1};
   logic [15:0] w4 = '0;

   stream_arbiter_wrr #(.DATA_WIDTH(32), .N_INP(3), .WEIGHT_WIDTH(4)) u3 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr3), .weight_i(w3), .bus(b3.slave));
   stream_arbiter_wrr #(.DATA_WIDTH(32), .N_INP(4), .WEIGHT_WIDTH(4)) u4 (
      .clk_i(clk), .rst_i(rst), .clr_i(clr4), .weight_i(w4), .bus(b4.slave));

   typedef struct {
      bit         u;        // 0: 3-input instance, 1: 4-input instance
      logic [3:0] vld;
      logic [3:0] lst;
      logic       rdy;
      logic       clr;
      logic       exp_vld;
      logic [1:0] exp_idx;
      logic [3:0] exp_rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit u, input logic [3:0] vld, input logic [3:0] lst, input logic rdy,
                      input logic clr, input logic exp_vld, input logic [1:0] exp_idx,
                      input logic [3:0] exp_rdy);
      vec_t t;
      t.u = u; t.vld = vld; t.lst = lst; t.rdy = rdy; t.clr = clr;
      t.exp_vld = exp_vld; t.exp_idx = exp_idx; t.exp_rdy = exp_rdy;
      vecs.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] dval(input int k);
      return 32'hD000_0000 | 32'(k);
   endfunction

   initial begin
      int s[10] = '{0, 1, 1, 2, 2, 2, 0, 1, 1, 2};
      vec_t t;

      for (int k = 0; k < 3; k++) b3.inp_data[k*32 +: 32] = dval(k);
      for (int k = 0; k < 4; k++) b4.inp_data[k*32 +: 32] = dval(k);

`ifdef STREAM_ARBITER_WRR_OUT_REG_EN
      // Registered output: grant sequence 0,1,1,2,2,2,... appears one cycle late.
      add(0, 4'h7, 4'h7, 1, 0, 0, 2'd0, 4'd1 << s[0]);
      for (int i = 1; i < 10; i++) add(0, 4'h7, 4'h7, 1, 0, 1, 2'(s[i-1]), 4'd1 << s[i]);
`else
      // Weights 1,2,3, single-beat packets.
      for (int i = 0; i < 9; i++) add(0, 4'h7, 4'h7, 1, 0, 1, 2'(s[i]), 4'd1 << s[i]);
      // Sink stalls: grant, data and state frozen; then ptr 2 resumes with a fresh count.
      for (int i = 0; i < 5; i++) add(0, 4'h7, 4'h7, 0, 0, 1, 2'd2, 4'h0);
      for (int i = 0; i < 3; i++) add(0, 4'h7, 4'h7, 1, 0, 1, 2'd2, 4'h4);
      // 3-beat in0 packet under toggling ready while in1 waits.
      add(0, 4'h3, 4'h2, 1, 0, 1, 2'd0, 4'h1);
      add(0, 4'h3, 4'h2, 0, 0, 1, 2'd0, 4'h0);
      add(0, 4'h3, 4'h2, 1, 0, 1, 2'd0, 4'h1);
      add(0, 4'h3, 4'h3, 0, 0, 1, 2'd0, 4'h0);
      add(0, 4'h3, 4'h3, 1, 0, 1, 2'd0, 4'h1);
      // ptr=1: in0 starts a packet alone, in1 arrives mid-packet and must wait.
      add(0, 4'h1, 4'h2, 1, 0, 1, 2'd0, 4'h1);
      add(0, 4'h3, 4'h2, 1, 0, 1, 2'd0, 4'h1);
      add(0, 4'h3, 4'h3, 1, 0, 1, 2'd0, 4'h1);
      add(0, 4'h3, 4'h3, 1, 0, 1, 2'd1, 4'h2);
      add(0, 4'h3, 4'h3, 1, 0, 1, 2'd1, 4'h2);
      // ptr=2 with in2 idle: search wraps to in0; then nothing valid -> sel = ptr.
      add(0, 4'h3, 4'h3, 1, 0, 1, 2'd0, 4'h1);
      add(0, 4'h0, 4'h0, 1, 0, 0, 2'd1, 4'h2);
      // Zero weights behave as weight 1.
      add(1, 4'hF, 4'hF, 1, 0, 1, 2'd0, 4'h1);
      add(1, 4'hF, 4'hF, 1, 0, 1, 2'd1, 4'h2);
      add(1, 4'hF, 4'hF, 1, 0, 1, 2'd2, 4'h4);
      add(1, 4'hF, 4'hF, 1, 0, 1, 2'd3, 4'h8);
      add(1, 4'hF, 4'hF, 1, 0, 1, 2'd0, 4'h1);
      for (int i = 0; i < 3; i++) add(1, 4'h4, 4'h4, 1, 0, 1, 2'd2, 4'h4);
      // ptr=3: in3 packet starts, clear during beat 2 (beat still moves), then in0 wins.
      add(1, 4'h9, 4'h1, 1, 0, 1, 2'd3, 4'h8);
      add(1, 4'h9, 4'h1, 1, 1, 1, 2'd3, 4'h8);
      add(1, 4'h9, 4'h1, 1, 0, 1, 2'd0, 4'h1);
`endif

      // Reset with traffic present: outputs held quiet.
      rst = 1'b1;
      b3.inp_valid = 3'h7; b3.inp_last = 3'h7; b3.oup_ready = 1'b1;
      b4.inp_valid = 4'h8; b4.inp_last = 4'hF; b4.oup_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst u3 valid", 32'(b3.oup_valid), 32'd0);
      chk("rst u3 ready", 32'(b3.inp_ready), 32'd0);
      chk("rst u3 idx",   32'(b3.oup_idx),   32'd0);
      chk("rst u4 valid", 32'(b4.oup_valid), 32'd0);
      chk("rst u4 ready", 32'(b4.inp_ready), 32'd0);
      chk("rst u4 idx",   32'(b4.oup_idx),   32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         t = vecs[i];
         if (t.u == 1'b0) begin
            b3.inp_valid = t.vld[2:0]; b3.inp_last = t.lst[2:0]; b3.oup_ready = t.rdy; clr3 = t.clr;
            b4.inp_valid = '0; b4.inp_last = '0; b4.oup_ready = 1'b0; clr4 = 1'b0;
         end else begin
            b4.inp_valid = t.vld; b4.inp_last = t.lst; b4.oup_ready = t.rdy; clr4 = t.clr;
            b3.inp_valid = '0; b3.inp_last = '0; b3.oup_ready = 1'b0; clr3 = 1'b0;
         end
         @(negedge clk);
         if (t.u == 1'b0) begin
            chk($sformatf("v%0d u3 valid", i), 32'(b3.oup_valid), 32'(t.exp_vld));
            chk($sformatf("v%0d u3 idx", i), 32'(b3.oup_idx), 32'(t.exp_idx));
            chk($sformatf("v%0d u3 ready", i), 32'(b3.inp_ready), 32'(t.exp_rdy));
            if (t.exp_vld) begin
               chk($sformatf("v%0d u3 data", i), b3.oup_data, dval(int'(t.exp_idx)));
               chk($sformatf("v%0d u3 last", i), 32'(b3.oup_last), 32'(t.lst[t.exp_idx]));
            end
         end else begin
            chk($sformatf("v%0d u4 valid", i), 32'(b4.oup_valid), 32'(t.exp_vld));
            chk($sformatf("v%0d u4 idx", i), 32'(b4.oup_idx), 32'(t.exp_idx));
            chk($sformatf("v%0d u4 ready", i), 32'(b4.inp_ready), 32'(t.exp_rdy));
            if (t.exp_vld) begin
               chk($sformatf("v%0d u4 data", i), b4.oup_data, dval(int'(t.exp_idx)));
               chk($sformatf("v%0d u4 last", i), 32'(b4.oup_last), 32'(t.lst[t.exp_idx]));
            end
         end
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
